// File: rtl/pong_game_ctrl.sv
// Match-level Pong controller: sequences START/SERVE/PLAY/DONE, keeps both
// scores, picks the serve direction and declares the match winner.
module pong_game_ctrl #(
  parameter logic [3:0]      WIN_SCORE   = 4'd7,
  parameter int unsigned     DELAY_W     = 24,
  parameter logic [DELAY_W-1:0] SERVE_DELAY = DELAY_W'(12_500_000)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ballStatus,
  output logic [1:0] state,
  output logic       serve,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned WIN_W   = 2;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } game_state_t;

  game_state_t        cur_state, nxt_state;
  logic [DELAY_W-1:0] cnt_q, cnt_n;
  logic               serve_q, serve_n;
  logic [SCORE_W-1:0] score1_q, score1_n;
  logic [SCORE_W-1:0] score2_q, score2_n;
  logic [WIN_W-1:0]   winner_q, winner_n;
  logic               start_prev;
  logic               start_edge_c;
  logic [SCORE_W-1:0] score1_inc_c, score2_inc_c;

  assign start_edge_c = start & ~start_prev;
  assign score1_inc_c = score1_q + SCORE_W'(1);
  assign score2_inc_c = score2_q + SCORE_W'(1);

  // State and datapath registers; start_prev resets high so a held button never fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= ST_START;
      cnt_q      <= '0;
      serve_q    <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      winner_q   <= '0;
      start_prev <= 1'b1;
    end else begin
      cur_state  <= nxt_state;
      cnt_q      <= cnt_n;
      serve_q    <= serve_n;
      score1_q   <= score1_n;
      score2_q   <= score2_n;
      winner_q   <= winner_n;
      start_prev <= start;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    nxt_state = cur_state;
    cnt_n     = cnt_q;
    serve_n   = serve_q;
    score1_n  = score1_q;
    score2_n  = score2_q;
    winner_n  = winner_q;

    case (cur_state)
      ST_START: begin
        score1_n = '0;
        score2_n = '0;
        winner_n = '0;
        if (start_edge_c) begin
          nxt_state = ST_SERVE;
          cnt_n     = '0;
          serve_n   = 1'b0;
        end
      end

      ST_SERVE: begin
        if (cnt_q == SERVE_DELAY - DELAY_W'(1)) begin
          nxt_state = ST_PLAY;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt_q + DELAY_W'(1);
        end
      end

      // Leaving PLAY on the scoring edge makes a lingering status count once.
      ST_PLAY: begin
        case (ballStatus)
          2'b01: begin
            score1_n = score1_inc_c;
            serve_n  = 1'b0;
            cnt_n    = '0;
            if (score1_inc_c == WIN_SCORE) begin
              winner_n  = 2'b01;
              nxt_state = ST_DONE;
            end else begin
              nxt_state = ST_SERVE;
            end
          end
          2'b10: begin
            score2_n = score2_inc_c;
            serve_n  = 1'b1;
            cnt_n    = '0;
            if (score2_inc_c == WIN_SCORE) begin
              winner_n  = 2'b10;
              nxt_state = ST_DONE;
            end else begin
              nxt_state = ST_SERVE;
            end
          end
          default: ;
        endcase
      end

      ST_DONE: begin
        if (start_edge_c) begin
          nxt_state = ST_START;
          score1_n  = '0;
          score2_n  = '0;
          winner_n  = '0;
        end
      end

      default: nxt_state = ST_START;
    endcase
  end

  assign state  = cur_state;
  assign serve  = serve_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the driver queues expected outputs per
// cycle, a monitor pops and compares them just after each rising edge.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] ballStatus;
  logic [1:0] state;
  logic       serve;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;

  int n_vec;
  int n_err;
  int cyc;

  typedef struct {
    int         at;
    string      name;
    logic [1:0] st;
    logic       sv;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] w;
  } exp_t;

  exp_t exp_q[$];

  pong_game_ctrl #(
    .WIN_SCORE  (4'd3),
    .DELAY_W    (8),
    .SERVE_DELAY(8'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ballStatus(ballStatus),
    .state     (state),
    .serve     (serve),
    .score1    (score1),
    .score2    (score2),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whatever expectation is due on this edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL %s: expectation for cycle %0d never checked", exp_q[0].name, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec = n_vec + 1;
      if ({state, serve, score1, score2, winner} !== {e.st, e.sv, e.s1, e.s2, e.w}) begin
        n_err = n_err + 1;
        $display("FAIL %s: got st=%b sv=%b s1=%0d s2=%0d w=%b, want st=%b sv=%b s1=%0d s2=%0d w=%b",
                 e.name, state, serve, score1, score2, winner, e.st, e.sv, e.s1, e.s2, e.w);
      end
    end
  end

  // Drive inputs for the coming edge and queue the outputs expected after it.
  task automatic step(input string name, input logic s, input logic [1:0] b,
                      input logic [1:0] st, input logic sv, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [1:0] w);
    exp_t e;
    start      = s;
    ballStatus = b;
    e.at   = cyc + 1;
    e.name = name;
    e.st   = st;
    e.sv   = sv;
    e.s1   = s1;
    e.s2   = s2;
    e.w    = w;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Remaining SERVE cycles after a point edge, then the entry into PLAY.
  task automatic serve_rest(input string name, input logic sv, input logic [3:0] s1,
                            input logic [3:0] s2);
    for (int i = 0; i < 3; i++) step(name, 1'b0, 2'b00, 2'b01, sv, s1, s2, 2'b00);
    step(name, 1'b0, 2'b00, 2'b10, sv, s1, s2, 2'b00);
  endtask

  // Immediate comparison against reset values, independent of the clock.
  task automatic check_reset(input string name);
    n_vec = n_vec + 1;
    if ({state, serve, score1, score2, winner} !== 13'b0) begin
      n_err = n_err + 1;
      $display("FAIL %s: got st=%b sv=%b s1=%0d s2=%0d w=%b, want all zero",
               name, state, serve, score1, score2, winner);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (exp_q.size() > 0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst        = 1'b0;
    start      = 1'b1;
    ballStatus = 2'b00;
    #23;
    check_reset("reset_values");
    @(negedge clk);
    rst = 1'b1;

    // Button held through reset release must not fire.
    step("held_start_0", 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00);
    step("held_start_1", 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00);
    step("released",     1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00);
    step("press_serve",  1'b1, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    step("serve_c1",     1'b1, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    step("serve_c2",     1'b1, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    step("serve_c3",     1'b0, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    step("enter_play",   1'b0, 2'b00, 2'b10, 1'b0, 4'd0, 4'd0, 2'b00);
    step("start_in_play",1'b1, 2'b00, 2'b10, 1'b0, 4'd0, 4'd0, 2'b00);
    step("play_idle",    1'b0, 2'b00, 2'b10, 1'b0, 4'd0, 4'd0, 2'b00);

    // Status held for five cycles scores once.
    step("p1_point",     1'b0, 2'b01, 2'b01, 1'b0, 4'd1, 4'd0, 2'b00);
    for (int i = 0; i < 3; i++)
      step("p1_hold_serve", 1'b0, 2'b01, 2'b01, 1'b0, 4'd1, 4'd0, 2'b00);
    step("p1_hold_play", 1'b0, 2'b01, 2'b10, 1'b0, 4'd1, 4'd0, 2'b00);

    step("status11_a",   1'b0, 2'b11, 2'b10, 1'b0, 4'd1, 4'd0, 2'b00);
    step("status11_b",   1'b0, 2'b11, 2'b10, 1'b0, 4'd1, 4'd0, 2'b00);

    // Player2 runs the match out to WIN_SCORE=3.
    step("p2_point1",    1'b0, 2'b10, 2'b01, 1'b1, 4'd1, 4'd1, 2'b00);
    serve_rest("p2_serve1", 1'b1, 4'd1, 4'd1);
    step("p2_point2",    1'b0, 2'b10, 2'b01, 1'b1, 4'd1, 4'd2, 2'b00);
    serve_rest("p2_serve2", 1'b1, 4'd1, 4'd2);
    step("p2_match",     1'b0, 2'b10, 2'b11, 1'b1, 4'd1, 4'd3, 2'b10);
    step("done_frozen0", 1'b0, 2'b01, 2'b11, 1'b1, 4'd1, 4'd3, 2'b10);
    step("done_frozen1", 1'b0, 2'b10, 2'b11, 1'b1, 4'd1, 4'd3, 2'b10);
    step("done_restart", 1'b1, 2'b00, 2'b00, 1'b1, 4'd0, 4'd0, 2'b00);
    step("start_idle",   1'b0, 2'b00, 2'b00, 1'b1, 4'd0, 4'd0, 2'b00);

    // Second match reaches 2-1, then reset lands mid-SERVE.
    step("m2_start",     1'b1, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    serve_rest("m2_serve0", 1'b0, 4'd0, 4'd0);
    step("m2_p1",        1'b0, 2'b01, 2'b01, 1'b0, 4'd1, 4'd0, 2'b00);
    serve_rest("m2_serve1", 1'b0, 4'd1, 4'd0);
    step("m2_p2",        1'b0, 2'b10, 2'b01, 1'b1, 4'd1, 4'd1, 2'b00);
    serve_rest("m2_serve2", 1'b1, 4'd1, 4'd1);
    step("m2_p1b",       1'b0, 2'b01, 2'b01, 1'b0, 4'd2, 4'd1, 2'b00);
    step("m2_serving",   1'b0, 2'b00, 2'b01, 1'b0, 4'd2, 4'd1, 2'b00);
    drain();

    #2;
    rst = 1'b0;
    #1;
    check_reset("async_reset_mid_serve");
    @(negedge clk);
    check_reset("reset_held");
    rst = 1'b1;
    step("after_reset",  1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00);
    step("after_press",  1'b1, 2'b00, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match-level controller for Pong.
- Consumes the ball engine's point-status output (2'b00 playing, 2'b01 player1 won point, 2'b10 player2 won point).
- Drives the 2-bit game state (START/SERVE/PLAY/DONE) and the serve direction bit that the ball engine and the display consume.
- Keeps per-player scores and declares the match winner.

Parameters:
- WIN_SCORE, 4'd7, score at which a player wins the match (legal range 1..15).
- DELAY_W, 24, width of the serve-delay counter.
- SERVE_DELAY, 24'd12_500_000, cycles spent in SERVE before PLAY (legal range 2..2^DELAY_W-1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  debounced start button, level; only rising edges act
- ballStatus  input  2  point status from ball engine
- state  output  2  game state: 00 START, 01 SERVE, 10 PLAY, 11 DONE
- serve  output  1  serve direction: 0 = ball toward player2 (+X), 1 = toward player1 (-X)
- score1  output  4  player1 points
- score2  output  4  player2 points
- winner  output  2  00 none, 01 player1, 10 player2

Behaviour:
- Reset (rst low, async): state=START, serve=0, score1=0, score2=0, winner=00, delay counter=0, start_prev=1. Reset mid-match discards scores immediately.
- start_prev resets to 1, so a button held through reset release does not fire. The button must be released and pressed again.
- Edge detect: start_edge = start & ~start_prev; start_prev<=start every cycle. All outputs are registered, so every decision is one clock after its cause.
- START: hold scores and winner at 0. On start_edge: go to SERVE, clear delay counter, serve<=0.
- SERVE:
  - Delay counter increments each cycle. When counter==SERVE_DELAY-1: go to PLAY, counter<=0.
  - ballStatus is ignored in SERVE. The ball engine clears its status one cycle after entering SERVE, which is why SERVE_DELAY>=2.
  - start_edge is ignored.
- PLAY, ballStatus==01:
  - score1<=score1+1, serve<=0 (toward loser, player2).
  - If score1+1==WIN_SCORE: winner<=01, go to DONE. Otherwise go to SERVE with counter cleared.
- PLAY, ballStatus==10: mirror of the 01 case. score2 increments, serve<=1, winner<=10 on match.
- PLAY, ballStatus==00: stay in PLAY. ballStatus==11 is invalid and treated as 00.
- PLAY, point scoring: state leaves PLAY on the same edge that records the point, so a status that persists for several cycles scores exactly once. start_edge is ignored in PLAY.
- Score arithmetic: 4-bit. Scores never exceed WIN_SCORE, so no wrap is possible.
- DONE: scores and winner frozen for display. On start_edge: go to START with score1, score2 and winner cleared to 0.
- Simultaneous events: reset dominates everything. ballStatus is only sampled in PLAY, so it cannot collide with start_edge.

Test Plan:
- Reset, then start held high through rst release -> state stays 00. Release start, then press -> state=01 one cycle after the edge.
- SERVE_DELAY=4, start pulse -> state=01 for exactly 4 cycles, then 10. serve=0 throughout.
- In PLAY, hold ballStatus=01 for 5 cycles -> score1=1 (not 5), serve=0, state=01 next cycle. After 4 cycles, state=10.
- In PLAY, pulse ballStatus=10 -> score2 increments and serve=1. Set ballStatus=11 in PLAY -> no change, state stays 10.
- WIN_SCORE=3, player2 scores 3 points -> on the third point state=11, winner=10, score2=3. start pulse -> state=00, all scores and winner 0.
- Score 2-1, then drive rst low mid-SERVE -> all outputs return to reset values without waiting for a clock edge.
